// File: rtl/pipeline_debug_ctrl.sv
`default_nettype none
// ==========================================================================
// pipeline_debug_ctrl : program loader and run/step/drain sequencer for a pipeline
// Revision 1.0
// ==========================================================================
module pipeline_debug_ctrl #(
  parameter int                 NB_DATA      = 32,
  parameter int                 NB_ADDR      = 32,
  parameter int                 IMEM_WORDS   = 256,
  parameter int                 DRAIN_CYCLES = 4,
  parameter logic [NB_DATA-1:0] HALT_WORD    = NB_DATA'(32'hFFFFFFFF)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [2:0]         i_cmd,
  input  logic               i_byte_valid,
  input  logic [7:0]         i_byte,
  input  logic [NB_DATA-1:0] i_instruction,
  output logic               o_write_instruction_mem,
  output logic [NB_ADDR-1:0] o_instruction_mem_addr,
  output logic [NB_DATA-1:0] o_instruction_mem_data,
  output logic               o_halt,
  output logic [2:0]         o_state,
  output logic [31:0]        o_cycle_count,
  output logic               o_done,
  output logic               o_load_error
);

  localparam int C_NB_BYTES = NB_DATA / 8;
  localparam int C_BC_W     = (C_NB_BYTES > 1) ? $clog2(C_NB_BYTES) : 1;
  localparam int C_WI_W     = $clog2(IMEM_WORDS + 1);
  localparam int C_DC_W     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [C_BC_W-1:0]  r_byte_cnt;
  logic [NB_DATA-1:0] r_asm;
  logic [C_WI_W-1:0]  r_word_idx;
  logic [C_DC_W-1:0]  r_drain_cnt;
  logic [NB_DATA-1:0] w_word;
  logic               w_word_done;
  logic               w_overflow;
  logic               w_cmd_load;
  logic               w_cmd_run;
  logic               w_cmd_step;
  logic               w_cmd_stop;
  logic               w_load_accept;

  assign w_cmd_load    = i_cmd_valid && (i_cmd == 3'd0);
  assign w_cmd_run     = i_cmd_valid && (i_cmd == 3'd1);
  assign w_cmd_step    = i_cmd_valid && (i_cmd == 3'd2);
  assign w_cmd_stop    = i_cmd_valid && (i_cmd == 3'd3);
  assign w_load_accept = w_cmd_load && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Bytes arrive MSB-first, so each new byte shifts in at the bottom.
  assign w_word      = (r_asm << 8) | NB_DATA'(i_byte);
  assign w_word_done = (r_state == S_LOAD) && i_byte_valid &&
                       (r_byte_cnt == C_BC_W'(C_NB_BYTES - 1));
  assign w_overflow  = (r_word_idx == C_WI_W'(IMEM_WORDS));

  assign o_state = r_state;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_load)      w_next_state = S_LOAD;
        else if (w_cmd_run)  w_next_state = S_RUN;
        else if (w_cmd_step) w_next_state = S_STEP;
      end
      S_LOAD: begin
        if (w_word_done && (w_overflow || (w_word == HALT_WORD)))
          w_next_state = S_IDLE;
      end
      S_RUN: begin
        if ((i_instruction == HALT_WORD) || w_cmd_stop) w_next_state = S_DRAIN;
      end
      S_STEP: begin
        w_next_state = (i_instruction == HALT_WORD) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (r_drain_cnt == C_DC_W'(DRAIN_CYCLES - 1)) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (w_cmd_load) w_next_state = S_LOAD;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state                 <= S_IDLE;
      r_byte_cnt              <= '0;
      r_asm                   <= '0;
      r_word_idx              <= '0;
      r_drain_cnt             <= '0;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= '0;
      o_instruction_mem_data  <= '0;
      o_halt                  <= 1'b1;
      o_cycle_count           <= '0;
      o_done                  <= 1'b0;
      o_load_error            <= 1'b0;
    end else begin
      r_state                 <= w_next_state;
      // Outputs are derived from the next state so they line up with o_state.
      o_halt                  <= !((w_next_state == S_RUN) || (w_next_state == S_STEP));
      o_done                  <= (w_next_state == S_DONE);
      o_write_instruction_mem <= 1'b0;

      if (w_load_accept) begin
        o_cycle_count <= '0;
        o_load_error  <= 1'b0;
        r_byte_cnt    <= '0;
        r_asm         <= '0;
        r_word_idx    <= '0;
      end

      if ((r_state == S_RUN) || (r_state == S_STEP))
        o_cycle_count <= o_cycle_count + 32'd1;

      if ((r_state == S_LOAD) && i_byte_valid) begin
        if (w_word_done) begin
          r_byte_cnt <= '0;
          r_asm      <= '0;
          if (w_overflow) begin
            o_load_error <= 1'b1;
            r_word_idx   <= '0;
          end else begin
            o_write_instruction_mem <= 1'b1;
            o_instruction_mem_data  <= w_word;
            o_instruction_mem_addr  <= NB_ADDR'({r_word_idx, 2'b00});
            r_word_idx <= (w_word == HALT_WORD) ? '0 : r_word_idx + C_WI_W'(1);
          end
        end else begin
          r_asm      <= w_word;
          r_byte_cnt <= r_byte_cnt + C_BC_W'(1);
        end
      end

      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + C_DC_W'(1);
      else                    r_drain_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_debug_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_pipeline_debug_ctrl : directed self-checking bench for pipeline_debug_ctrl
// Revision 1.0
// ==========================================================================
module tb_pipeline_debug_ctrl;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic [31:0] instr = 32'd0;

  logic        wr, wr_s;
  logic [31:0] addr, addr_s;
  logic [31:0] data, data_s;
  logic        halt, halt_s;
  logic [2:0]  state, state_s;
  logic [31:0] cnt, cnt_s;
  logic        done, done_s;
  logic        err, err_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_debug_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_byte_valid(byte_valid), .i_byte(byte_in), .i_instruction(instr),
    .o_write_instruction_mem(wr), .o_instruction_mem_addr(addr),
    .o_instruction_mem_data(data), .o_halt(halt), .o_state(state),
    .o_cycle_count(cnt), .o_done(done), .o_load_error(err)
  );

  pipeline_debug_ctrl #(.IMEM_WORDS(4)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_byte_valid(byte_valid), .i_byte(byte_in), .i_instruction(instr),
    .o_write_instruction_mem(wr_s), .o_instruction_mem_addr(addr_s),
    .o_instruction_mem_data(data_s), .o_halt(halt_s), .o_state(state_s),
    .o_cycle_count(cnt_s), .o_done(done_s), .o_load_error(err_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    tick();
    tick();
    // Reset values
    chk("rst_state", state, 3'd0);
    chk("rst_halt", halt, 1'b1);
    chk("rst_wr", wr, 1'b0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;

    // Bytes outside LOAD are ignored
    send_byte(8'hAA);
    chk("idle_byte_wr", wr, 1'b0);
    chk("idle_byte_state", state, 3'd0);

    // Load two words, last one HALT
    send_cmd(3'd0);
    chk("load_state", state, 3'd1);
    send_cmd(3'd1);
    chk("load_ignores_cmd", state, 3'd1);
    send_byte(8'h20); chk("ld_b0_wr", wr, 1'b0);
    send_byte(8'h01); chk("ld_b1_wr", wr, 1'b0);
    send_byte(8'h00); chk("ld_b2_wr", wr, 1'b0);
    send_byte(8'h05);
    chk("ld_w0_wr", wr, 1'b1);
    chk("ld_w0_data", data, 32'h20010005);
    chk("ld_w0_addr", addr, 32'h0);
    chk("ld_w0_state", state, 3'd1);
    tick();
    chk("ld_w0_pulse_end", wr, 1'b0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    chk("ld_b6_wr", wr, 1'b0);
    send_byte(8'hFF);
    chk("ld_w1_wr", wr, 1'b1);
    chk("ld_w1_data", data, 32'hFFFFFFFF);
    chk("ld_w1_addr", addr, 32'h4);
    chk("ld_w1_state", state, 3'd0);
    tick();
    chk("ld_w1_pulse_end", wr, 1'b0);

    // Run, HALT on third cycle, drain, done
    send_cmd(3'd1);
    chk("run_state", state, 3'd2);
    chk("run_halt", halt, 1'b0);
    chk("run_cnt0", cnt, 32'd0);
    tick(); chk("run_cnt1", cnt, 32'd1);
    tick(); chk("run_cnt2", cnt, 32'd2);
    instr = HALT;
    tick();
    instr = 32'd0;
    chk("run_cnt3", cnt, 32'd3);
    chk("run_to_drain", state, 3'd4);
    chk("drain_halt0", halt, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_state", state, 3'd4);
      chk("drain_halt", halt, 1'b1);
    end
    tick();
    chk("done_state", state, 3'd5);
    chk("done_flag", done, 1'b1);
    chk("done_cnt", cnt, 32'd3);
    send_cmd(3'd1);
    chk("done_ignores_run", state, 3'd5);
    send_cmd(3'd0);
    chk("done_load_state", state, 3'd1);
    chk("done_load_clr_done", done, 1'b0);
    chk("done_load_clr_cnt", cnt, 32'd0);

    // Two single steps
    do_reset();
    send_cmd(3'd2);
    chk("step1_state", state, 3'd3);
    chk("step1_halt", halt, 1'b0);
    tick();
    chk("step1_idle", state, 3'd0);
    chk("step1_halt_back", halt, 1'b1);
    chk("step1_cnt", cnt, 32'd1);
    tick();
    chk("step_gap_halt", halt, 1'b1);
    send_cmd(3'd2);
    chk("step2_halt", halt, 1'b0);
    tick();
    chk("step2_cnt", cnt, 32'd2);
    chk("step2_idle", state, 3'd0);
    // Step onto HALT goes to drain
    send_cmd(3'd2);
    instr = HALT;
    tick();
    instr = 32'd0;
    chk("step_halt_drain", state, 3'd4);
    chk("step_halt_cnt", cnt, 32'd3);

    // STOP together with HALT: single drain of 4 cycles
    do_reset();
    send_cmd(3'd1);
    cmd_valid = 1'b1; cmd = 3'd3; instr = HALT;
    tick();
    cmd_valid = 1'b0; instr = 32'd0;
    chk("stop_drain", state, 3'd4);
    chk("stop_cnt", cnt, 32'd1);
    tick(); tick(); tick();
    chk("stop_drain_last", state, 3'd4);
    tick();
    chk("stop_done", state, 3'd5);
    chk("stop_done_flag", done, 1'b1);

    // Reset in the middle of a word
    do_reset();
    send_cmd(3'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    chk("midrst_state", state, 3'd0);
    chk("midrst_wr", wr, 1'b0);
    rst = 1'b0;
    tick();
    chk("midrst_wr2", wr, 1'b0);
    send_cmd(3'd0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    chk("reload_wr", wr, 1'b1);
    chk("reload_data", data, 32'h12345678);
    chk("reload_addr", addr, 32'h0);

    // Overflow on the 4-word instance
    do_reset();
    send_cmd(3'd0);
    chk("ovf_load_state", state_s, 3'd1);
    for (int k = 0; k < 5; k++) begin
      w = 32'(k + 1);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(w[7:0]);
      if (k < 4) begin
        chk("ovf_wr", wr_s, 1'b1);
        chk("ovf_addr", addr_s, 32'(4 * k));
        chk("ovf_data", data_s, w);
        chk("ovf_state_load", state_s, 3'd1);
        chk("ovf_err_low", err_s, 1'b0);
      end else begin
        chk("ovf_5th_no_wr", wr_s, 1'b0);
        chk("ovf_err", err_s, 1'b1);
        chk("ovf_idle", state_s, 3'd0);
      end
    end
    tick();
    chk("ovf_err_sticky", err_s, 1'b1);
    send_cmd(3'd0);
    chk("ovf_err_clr", err_s, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_debug_ctrl.md
PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NB_DATA, 32, instruction word width (multiple of 8); NB_ADDR, 32, instruction memory byte-address width; IMEM_WORDS, 256, instruction memory capacity in words; DRAIN_CYCLES, 4, cycles to flush stages after fetch halts; HALT_WORD, 32'hFFFFFFFF, end-of-program instruction.
REQ-002 One clock; reset is synchronous and active-high (ports i_clk, i_reset).
REQ-003 Ports (name, direction, width, meaning):
- i_clk, in, 1, clock
- i_reset, in, 1, synchronous active-high reset
- i_cmd_valid, in, 1, command strobe, one cycle
- i_cmd, in, 3, 0=LOAD, 1=RUN, 2=STEP, 3=STOP; other codes are no-ops
- i_byte_valid, in, 1, program byte strobe
- i_byte, in, 8, program byte
- i_instruction, in, NB_DATA, instruction currently leaving fetch
- o_write_instruction_mem, out, 1, instruction memory write enable
- o_instruction_mem_addr, out, NB_ADDR, write byte address
- o_instruction_mem_data, out, NB_DATA, write data
- o_halt, out, 1, freezes PC/fetch when 1
- o_state, out, 3, FSM state encoding
- o_cycle_count, out, 32, cycles executed with o_halt=0
- o_done, out, 1, program finished and pipeline drained
- o_load_error, out, 1, program exceeded IMEM_WORDS

Function
REQ-004 FSM states and encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, DRAIN=4, DONE=5.
REQ-005 IDLE: LOAD cmd -> LOAD; RUN cmd -> RUN; STEP cmd -> STEP; STOP cmd ignored.
REQ-006 LOAD: bytes assembled MSB-first; the NB_DATA/8-th byte completes a word.
REQ-007 Word completion: o_write_instruction_mem=1 for exactly one cycle, with o_instruction_mem_data = word and o_instruction_mem_addr = 4*word_index.
REQ-008 Write cycle timing: the write pulse occurs on the cycle after the final byte strobe.
REQ-009 LOAD exit on HALT_WORD: the completed HALT_WORD is written, then the block returns to IDLE and the word index resets to 0.
REQ-010 LOAD overflow: a word completed when word_index == IMEM_WORDS is not written, sets o_load_error (sticky until the next LOAD cmd or reset), and returns the block to IDLE.
REQ-011 LOAD cmd clears o_done, o_load_error, o_cycle_count and the partial-byte counter.
REQ-012 Commands received in LOAD are ignored.
REQ-013 i_byte_valid is ignored outside LOAD.
REQ-014 RUN behaviour: o_halt=0, and o_cycle_count increments each cycle.
REQ-015 RUN exit: i_instruction == HALT_WORD or STOP cmd -> DRAIN on the next cycle.
REQ-016 RUN precedence: if both exit conditions occur in the same cycle, DRAIN is entered once.
REQ-017 STEP: o_halt=0 for exactly one cycle and o_cycle_count increments by 1.
REQ-018 STEP exit: next state is DRAIN if i_instruction == HALT_WORD in that cycle, else IDLE.
REQ-019 DRAIN: o_halt=1 while a counter runs DRAIN_CYCLES cycles, then the block enters DONE; commands are ignored.
REQ-020 DONE: o_done=1; a LOAD cmd is accepted, all other commands are ignored.
REQ-021 o_cycle_count wraps from 2^32-1 to 0 with no flag.
REQ-022 o_halt=1 in every state except RUN and the single STEP cycle.
REQ-023 All outputs are registered.

Reset
REQ-024 i_reset=1 on any edge forces state IDLE, including mid-LOAD, mid-RUN and mid-DRAIN.
REQ-025 Reset output values: o_halt=1; o_write_instruction_mem=0; o_instruction_mem_addr=0; o_instruction_mem_data=0; o_cycle_count=0; o_done=0; o_load_error=0.
REQ-026 Reset clears all internal counters; a partially assembled word is discarded.

Verification
REQ-027 Load: LOAD, then bytes 20 01 00 05 FF FF FF FF -> writes 0x20010005 @0x0 and 0xFFFFFFFF @0x4, one pulse each, return to IDLE.
REQ-028 Run: after REQ-027, RUN, i_instruction=HALT_WORD on the 3rd cycle -> o_cycle_count=3, o_halt=1 for 4 cycles in DRAIN, then o_done=1.
REQ-029 Step: STEP x2 with non-halt i_instruction -> two isolated 1-cycle o_halt=0 pulses, o_cycle_count=2, state IDLE.
REQ-030 Overflow: IMEM_WORDS=4, load 5 non-halt words -> 4 writes (addresses 0x0-0xC), 5th not written, o_load_error=1, state IDLE.
REQ-031 Stop: STOP during RUN together with HALT_WORD on i_instruction -> single DRAIN, DONE reached after exactly DRAIN_CYCLES cycles.
REQ-032 Reset: i_reset asserted after 2 of 4 bytes in LOAD -> IDLE, no write pulse; a new load starts at address 0.
